// File: rtl/synth_audio_pkg.sv
// Shared constants for the synth audio output path.
package synth_audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;
    localparam int I2S_SLOT_WIDTH   = 32;
    localparam int I2S_BCLK_DIV     = 4;

    // clk_i cycles per stereo frame (left slot + right slot)
    localparam int FRAME_CYCLES = 2 * I2S_SLOT_WIDTH * I2S_BCLK_DIV;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing generator: bit clock divider, frame bit counter and the
// strobes the transmitter uses to line data up with BCLK edges.
module i2s_clk_gen
    import synth_audio_pkg::*;
#(
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int BCLK_DIV   = I2S_BCLK_DIV,
    parameter int POS_W      = $clog2(I2S_SLOT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bclk,
    output logic             lrclk,
    output logic             bit_tick,
    output logic             bit_end,
    output logic             frame_end,
    output logic [POS_W-1:0] slot_pos
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] pos_full;

    // div_cnt runs every cycle; bit_cnt steps once per BCLK period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // all timing outputs are pure decodes of the two counters
    always_comb begin
        bclk      = (div_cnt >= DIV_HALF);
        lrclk     = (bit_cnt >= SLOT_LEN);
        bit_tick  = (div_cnt == '0);
        bit_end   = (div_cnt == DIV_LAST);
        frame_end = (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);
        pos_full  = lrclk ? (bit_cnt - SLOT_LEN) : bit_cnt;
        slot_pos  = pos_full[POS_W-1:0];
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry holding buffer in front of a frame-rate
// active register; the active sample is shifted out MSB first in both
// the left and right slots with the standard one-bit I2S delay.
module i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int BCLK_DIV   = I2S_BCLK_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  underrun_o
);

    localparam int POS_W = $clog2(SLOT_WIDTH);
    localparam logic [POS_W-1:0] POS_DATA_END = POS_W'(DATA_WIDTH);

    logic                  bit_tick;
    logic                  bit_end;
    logic                  frame_end;
    logic [POS_W-1:0]      slot_pos;
    logic [DATA_WIDTH-1:0] pending;
    logic                  pending_full;
    logic [DATA_WIDTH-1:0] active;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  accept;

    i2s_clk_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .BCLK_DIV   (BCLK_DIV),
        .POS_W      (POS_W)
    ) u_clk_gen (
        .clk       (clk_i),
        .rst       (rst_i),
        .bclk      (bclk_o),
        .lrclk     (lrclk_o),
        .bit_tick  (bit_tick),
        .bit_end   (bit_end),
        .frame_end (frame_end),
        .slot_pos  (slot_pos)
    );

    assign accept     = valid_i && !pending_full;
    assign ready_o    = !pending_full;
    assign underrun_o = frame_end && !pending_full;
    assign sdata_o    = (slot_pos != '0) && (slot_pos <= POS_DATA_END) ? shift_reg[DATA_WIDTH-1] : 1'b0;

    // holding buffer fills on accept and drains at the frame boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (accept) begin
            pending      <= data_i;
            pending_full <= 1'b1;
        end else if (frame_end && pending_full) begin
            pending_full <= 1'b0;
        end
    end

    // active sample only changes at a frame boundary; silence on underrun
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active <= '0;
        end else if (frame_end) begin
            active <= pending_full ? pending : '0;
        end
    end

    // reload at each slot start (data is gated off there), shift between data bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_reg <= '0;
        end else if (bit_tick && (slot_pos == '0)) begin
            shift_reg <= active;
        end else if (bit_end && (slot_pos != '0) && (slot_pos < POS_DATA_END)) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: per-cycle timing checks, a frame deserializer that
// compares each slot against a queue of scheduled samples, ready/valid
// vector tables and hand-written stall and reset sequences.
module tb_i2s_tx;
    import synth_audio_pkg::*;

    localparam int DW    = AUDIO_DATA_WIDTH;
    localparam int SW    = I2S_SLOT_WIDTH;
    localparam int BD    = I2S_BCLK_DIV;
    localparam int FRAME = FRAME_CYCLES;
    localparam int BITS  = 2 * SW;

    typedef struct {
        int          frame;
        logic [15:0] sample;
    } sb_t;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [15:0] data;
        logic        exp_ready;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    int            cyc;
    int            checks;
    int            errors;
    sb_t           sb[$];
    vec_t          vecs[$];
    logic [BITS-1:0] frame_bits;
    logic          bit_latch;

    i2s_tx #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .BCLK_DIV   (BD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .data_i     (data),
        .ready_o    (ready),
        .bclk_o     (bclk),
        .lrclk_o    (lrclk),
        .sdata_o    (sdata),
        .underrun_o (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
        valid = v;
        data  = d;
    endtask

    // A sample accepted in cycle t plays in the next frame, except one
    // accepted on the boundary cycle itself, which waits one more frame.
    task automatic scheduleSample(input logic [15:0] s);
        sb_t e;
        e.sample = s;
        e.frame  = ((cyc % FRAME) == FRAME - 1) ? (cyc / FRAME + 2) : (cyc / FRAME + 1);
        sb.push_back(e);
    endtask

    task automatic monitorCycle();
        int          pos;
        int          f;
        int          b;
        logic        exp_under;
        logic [15:0] exp_sample;
        logic [31:0] exp_word;
        pos = cyc % FRAME;
        f   = cyc / FRAME;
        checkOutput("bclk", bclk, ((cyc % BD) >= BD / 2));
        checkOutput("lrclk", lrclk, (pos >= FRAME / 2));
        exp_under = 1'b0;
        if (pos == FRAME - 1)
            exp_under = !(sb.size() > 0 && sb[0].frame == f + 1);
        checkOutput("underrun", underrun, exp_under);
        if ((cyc % BD) == 0) begin
            b = pos / BD;
            bit_latch = sdata;
            frame_bits[BITS-1-b] = sdata;
            if (b == BITS - 1) begin
                exp_sample = '0;
                if (sb.size() > 0 && sb[0].frame == f) begin
                    exp_sample = sb[0].sample;
                    void'(sb.pop_front());
                end
                exp_word = {1'b0, exp_sample, {(SW - DW - 1){1'b0}}};
                checkOutput("left_slot", frame_bits[BITS-1:SW], exp_word);
                checkOutput("right_slot", frame_bits[SW-1:0], exp_word);
            end
        end else if ((cyc % BD) == BD - 1) begin
            checkOutput("sdata_stable", sdata, bit_latch);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        monitorCycle();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput("rst_bclk", bclk, 1'b0);
        checkOutput("rst_lrclk", lrclk, 1'b0);
        checkOutput("rst_sdata", sdata, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
        checkOutput("rst_ready", ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        monitorCycle();
    endtask

    task automatic runUntil(input int end_cyc);
        while (cyc < end_cyc) begin
            stepCycle();
            applyStimulus(1'b0, '0);
        end
    endtask

    task automatic addVec(input int c, input logic v, input logic [15:0] d, input logic r);
        vec_t e;
        e.cyc       = c;
        e.valid     = v;
        e.data      = d;
        e.exp_ready = r;
        vecs.push_back(e);
    endtask

    task automatic runVectors(input int end_cyc);
        resetDut();
        foreach (vecs[i]) begin
            runUntil(vecs[i].cyc);
            checkOutput("vec_ready", ready, vecs[i].exp_ready);
            applyStimulus(vecs[i].valid, vecs[i].data);
            if (vecs[i].valid && vecs[i].exp_ready)
                scheduleSample(vecs[i].data);
        end
        runUntil(end_cyc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        frame_bits = '0;
        bit_latch  = 1'b0;
        applyStimulus(1'b0, '0);
        $display("[TB] i2s_tx bench start");

        // single sample accepted early in frame 0
        vecs.delete();
        addVec(0,   1'b0, 16'h0000, 1'b1);
        addVec(10,  1'b1, 16'hA5C3, 1'b1);
        addVec(11,  1'b0, 16'h0000, 1'b0);
        addVec(128, 1'b0, 16'h0000, 1'b0);
        addVec(255, 1'b0, 16'h0000, 1'b0);
        addVec(256, 1'b0, 16'h0000, 1'b1);
        addVec(300, 1'b0, 16'h0000, 1'b1);
        runVectors(3 * FRAME + 20);

        // idle: every boundary underruns, line stays silent
        vecs.delete();
        addVec(0,   1'b0, 16'h0000, 1'b1);
        addVec(255, 1'b0, 16'h0000, 1'b1);
        addVec(520, 1'b0, 16'h0000, 1'b1);
        runVectors(3 * FRAME + 20);

        // sample offered exactly on the boundary cycle
        vecs.delete();
        addVec(0,   1'b0, 16'h0000, 1'b1);
        addVec(255, 1'b1, 16'h8000, 1'b1);
        addVec(256, 1'b0, 16'h0000, 1'b0);
        addVec(511, 1'b0, 16'h0000, 1'b0);
        addVec(512, 1'b0, 16'h0000, 1'b1);
        runVectors(3 * FRAME + 20);

        // back-to-back samples: second one stalls until the buffer drains
        resetDut();
        runUntil(3);
        checkOutput("first_ready", ready, 1'b1);
        applyStimulus(1'b1, 16'h1234);
        scheduleSample(16'h1234);
        stepCycle();
        applyStimulus(1'b1, 16'h5678);
        checkOutput("full_ready", ready, 1'b0);
        while (cyc < FRAME) begin
            stepCycle();
            if (cyc < FRAME)
                checkOutput("stall_ready", ready, 1'b0);
        end
        checkOutput("resume_ready", ready, 1'b1);
        scheduleSample(16'h5678);
        stepCycle();
        applyStimulus(1'b0, '0);
        checkOutput("refill_ready", ready, 1'b0);
        runUntil(3 * FRAME + 20);

        // asynchronous reset mid-frame drops the pending sample
        resetDut();
        runUntil(5);
        checkOutput("ffff_ready0", ready, 1'b1);
        applyStimulus(1'b1, 16'hFFFF);
        scheduleSample(16'hFFFF);
        runUntil(260);
        checkOutput("ffff_ready1", ready, 1'b1);
        applyStimulus(1'b1, 16'hFFFF);
        scheduleSample(16'hFFFF);
        runUntil(300);
        checkOutput("pre_rst_sdata", sdata, 1'b1);
        checkOutput("pre_rst_ready", ready, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("async_bclk", bclk, 1'b0);
        checkOutput("async_lrclk", lrclk, 1'b0);
        checkOutput("async_sdata", sdata, 1'b0);
        checkOutput("async_underrun", underrun, 1'b0);
        checkOutput("async_ready", ready, 1'b1);
        resetDut();
        runUntil(2 * FRAME + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
